// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [2:0] {
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_WAIT,
        RF_DONE
    } cache_state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    // Byte-offset bits within one line.
    function automatic int offset_width(input int line_size);
        return $clog2(line_size / 8);
    endfunction

    // Line-index bits; num_lines is a power of two, at least 2.
    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Whatever address bits remain above index and offset.
    function automatic int tag_width(input int addr_size, input int line_size, input int num_lines);
        return addr_size - offset_width(line_size) - index_width(num_lines);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays with a word-or-byte merge port and a full-line refill port.
// Latency: combinational read of the indexed line; writes land at the next rising edge.
// Backpressure: none; the controller issues at most one write per cycle.
//
// Ports: clk, reset (sync, active-high, clears valid/dirty only);
//        index selects the line for both read and write;
//        line_valid/line_dirty/line_tag/line_data read the indexed line;
//        merge_* writes one word or byte and sets dirty;
//        fill_* installs a whole line, marks it valid and clean;
//        clean_en clears dirty once a write-back has been accepted.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int INDEX_W   = 2,
    parameter int TAG_W     = 26,
    parameter int LINE_W    = 128,
    parameter int WORD_W    = 32,
    parameter int OFFSET_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    output logic                line_valid,
    output logic                line_dirty,
    output logic [TAG_W-1:0]    line_tag,
    output logic [LINE_W-1:0]   line_data,
    input  logic                merge_en,
    input  logic                merge_byte,
    input  logic [OFFSET_W-1:0] merge_offset,
    input  logic [WORD_W-1:0]   merge_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [LINE_W-1:0]   fill_data,
    input  logic                clean_en
);

    localparam int BYTE_LSB = $clog2(WORD_W / 8);
    localparam int WORD_SH  = $clog2(WORD_W);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Bit positions inside the line; both are exactly log2(LINE_W) wide.
    logic [OFFSET_W+2:0] byte_base;
    logic [OFFSET_W+2:0] word_base;

    assign byte_base = {merge_offset, 3'b000};
    assign word_base = {merge_offset[OFFSET_W-1:BYTE_LSB], {WORD_SH{1'b0}}};

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];

    // Only the flags need reset: an invalid line's tag and data are never used.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[index] <= 1'b1;
            end
            if (fill_en || clean_en) begin
                dirty_q[index] <= 1'b0;
            end else if (merge_en) begin
                dirty_q[index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (merge_en) begin
            if (merge_byte) begin
                data_q[index][byte_base +: 8] <= merge_data[7:0];
            end else begin
                data_q[index][word_base +: WORD_W] <= merge_data;
            end
        end
    end

endmodule

// File: rtl/icache_unit.sv
// Direct-mapped write-back, write-allocate cache: 32-bit CPU port, 128-bit line refill/write-back.
// Latency: hit completes the cycle after access is sampled; miss adds write-back (if dirty) plus refill.
// Backpressure: CPU holds its request until data_ready; memory start waits while memory_in_use is high.
//
// Ports: clk, reset (sync, active-high);
//        CPU side: access, address, data_in, op (1 read / 0 write), byte_op -> data_out, data_ready;
//        memory side: mem_op_init, mem_enable, mem_op, mem_op_done, mem_address, mem_data_in
//                     <- mem_data_ready, mem_data_out, memory_in_use.
// Optional: define CACHE_STATS_EN to add hit_count and miss_count outputs.
module icache_unit
    import cache_pkg::*;
#(
    parameter int ADDRESS_SIZE    = 32,
    parameter int WORD_SIZE       = 32,
    parameter int CACHE_LINE_SIZE = 128,
    parameter int NUM_LINES       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       access,
    input  logic [ADDRESS_SIZE-1:0]    address,
    input  logic [WORD_SIZE-1:0]       data_in,
    input  logic                       op,
    input  logic                       byte_op,
    input  logic                       mem_data_ready,
    input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
    input  logic                       memory_in_use,
    output logic [WORD_SIZE-1:0]       data_out,
    output logic                       data_ready,
    output logic                       mem_op_init,
    output logic                       mem_enable,
    output logic                       mem_op,
    output logic                       mem_op_done,
    output logic [ADDRESS_SIZE-1:0]    mem_address,
    output logic [CACHE_LINE_SIZE-1:0] mem_data_in
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int OFFSET_W = offset_width(CACHE_LINE_SIZE);
    localparam int INDEX_W  = index_width(NUM_LINES);
    localparam int TAG_W    = tag_width(ADDRESS_SIZE, CACHE_LINE_SIZE, NUM_LINES);
    localparam int BYTE_LSB = $clog2(WORD_SIZE / 8);
    localparam int WORD_SH  = $clog2(WORD_SIZE);

    cache_state_t state, state_nxt;

    logic [OFFSET_W-1:0] addr_offset;
    logic [INDEX_W-1:0]  addr_index;
    logic [TAG_W-1:0]    addr_tag;

    logic                       line_valid;
    logic                       line_dirty;
    logic [TAG_W-1:0]           line_tag;
    logic [CACHE_LINE_SIZE-1:0] line_data;

    logic hit;
    logic do_read;
    logic do_write;
    logic do_miss;
    logic wb_issue;
    logic wb_finish;
    logic rf_issue;
    logic rf_fill;

    logic [OFFSET_W+2:0]     byte_base;
    logic [OFFSET_W+2:0]     word_base;
    logic [WORD_SIZE-1:0]    rd_result;
    logic [ADDRESS_SIZE-1:0] victim_addr;
    logic [ADDRESS_SIZE-1:0] fill_addr;

    assign addr_offset = address[OFFSET_W-1:0];
    assign addr_index  = address[OFFSET_W +: INDEX_W];
    assign addr_tag    = address[ADDRESS_SIZE-1 -: TAG_W];

    assign hit = line_valid && (line_tag == addr_tag);

    // Word reads drop the byte-within-word bits; byte reads zero-extend.
    assign byte_base = {addr_offset, 3'b000};
    assign word_base = {addr_offset[OFFSET_W-1:BYTE_LSB], {WORD_SH{1'b0}}};
    assign rd_result = byte_op ? {{(WORD_SIZE-8){1'b0}}, line_data[byte_base +: 8]}
                               : line_data[word_base +: WORD_SIZE];

    // The victim lives at the requested index under its own stored tag.
    assign victim_addr = {line_tag, addr_index, {OFFSET_W{1'b0}}};
    assign fill_addr   = {addr_tag, addr_index, {OFFSET_W{1'b0}}};

    cache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W),
        .LINE_W    (CACHE_LINE_SIZE),
        .WORD_W    (WORD_SIZE),
        .OFFSET_W  (OFFSET_W)
    ) u_store (
        .clk          (clk),
        .reset        (reset),
        .index        (addr_index),
        .line_valid   (line_valid),
        .line_dirty   (line_dirty),
        .line_tag     (line_tag),
        .line_data    (line_data),
        .merge_en     (do_write),
        .merge_byte   (byte_op),
        .merge_offset (addr_offset),
        .merge_data   (data_in),
        .fill_en      (rf_fill),
        .fill_tag     (addr_tag),
        .fill_data    (mem_data_out),
        .clean_en     (wb_finish)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOOKUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_read   = 1'b0;
        do_write  = 1'b0;
        do_miss   = 1'b0;
        wb_issue  = 1'b0;
        wb_finish = 1'b0;
        rf_issue  = 1'b0;
        rf_fill   = 1'b0;
        case (state)
            LOOKUP: begin
                if (access) begin
                    if (hit) begin
                        do_read  = (op == OP_READ);
                        do_write = (op == OP_WRITE);
                    end else begin
                        do_miss   = 1'b1;
                        state_nxt = (line_valid && line_dirty) ? WB_REQ : RF_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (!memory_in_use) begin
                    wb_issue  = 1'b1;
                    state_nxt = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (mem_data_ready) begin
                    wb_finish = 1'b1;
                    state_nxt = RF_REQ;
                end
            end
            RF_REQ: begin
                if (!memory_in_use) begin
                    rf_issue  = 1'b1;
                    state_nxt = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_data_ready) begin
                    rf_fill   = 1'b1;
                    state_nxt = RF_DONE;
                end
            end
            RF_DONE: begin
                // Return to LOOKUP so the still-held request retries and hits.
                state_nxt = LOOKUP;
            end
            default: begin
                state_nxt = LOOKUP;
            end
        endcase
    end

    // All outputs are registered: strobes decided this cycle appear next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= '0;
            data_ready  <= 1'b0;
            mem_op_init <= 1'b0;
            mem_enable  <= 1'b0;
            mem_op      <= 1'b0;
            mem_op_done <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            data_ready  <= do_read || do_write;
            mem_op_init <= wb_issue || rf_issue;
            mem_op_done <= wb_finish || rf_fill;
            if (do_read) begin
                data_out <= rd_result;
            end
            if (wb_issue) begin
                mem_enable  <= 1'b1;
                mem_op      <= OP_WRITE;
                mem_address <= victim_addr;
                mem_data_in <= line_data;
            end else if (rf_issue) begin
                mem_enable  <= 1'b1;
                mem_op      <= OP_READ;
                mem_address <= fill_addr;
            end else if (wb_finish || rf_fill) begin
                mem_enable  <= 1'b0;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // The post-refill retry is a fresh LOOKUP hit, so it counts as a hit too.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (do_read || do_write) begin
                hit_count <= hit_count + 32'd1;
            end
            if (do_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_unit.sv
// Scoreboard bench for icache_unit: directed CPU requests, a small line-memory model.
// Latency: memory model answers MEM_LAT cycles after each mem_op_init.
// Backpressure: memory_in_use driven by the stimulus to stall memory starts.
module tb_icache_unit;

    localparam int MEM_LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         access;
    logic [31:0]  address;
    logic [31:0]  data_in;
    logic         op;
    logic         byte_op;
    logic         mem_data_ready;
    logic [127:0] mem_data_out;
    logic         memory_in_use;
    logic [31:0]  data_out;
    logic         data_ready;
    logic         mem_op_init;
    logic         mem_enable;
    logic         mem_op;
    logic         mem_op_done;
    logic [31:0]  mem_address;
    logic [127:0] mem_data_in;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    icache_unit dut (
        .clk            (clk),
        .reset          (reset),
        .access         (access),
        .address        (address),
        .data_in        (data_in),
        .op             (op),
        .byte_op        (byte_op),
        .mem_data_ready (mem_data_ready),
        .mem_data_out   (mem_data_out),
        .memory_in_use  (memory_in_use),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .mem_op_init    (mem_op_init),
        .mem_enable     (mem_enable),
        .mem_op         (mem_op),
        .mem_op_done    (mem_op_done),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        string       name;
    } cpu_exp_t;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic        chk_wb;
        logic [31:0] wb_word;
        string       name;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int init_cnt = 0;
    int done_cnt = 0;
    int last_init_cyc = -1;

    logic [127:0] mem_store [logic [31:0]];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_ready) begin
            if (cpu_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_completion: got data_ready=1, required 0");
            end else begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                if (e.is_read) check(e.name, data_out, e.data);
            end
        end
        if (mem_op_init) begin
            init_cnt++;
            last_init_cyc = cyc;
            if (mem_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_mem_op: got mem_op_init=1 addr=%h, required 0", mem_address);
            end else begin
                mem_exp_t m;
                m = mem_q.pop_front();
                check({m.name, "_op"}, mem_op, m.op);
                check({m.name, "_addr"}, mem_address, m.addr);
                check({m.name, "_enable"}, mem_enable, 1'b1);
                check({m.name, "_not_in_use"}, memory_in_use, 1'b0);
                if (m.chk_wb) check({m.name, "_wb_word1"}, mem_data_in[63:32], m.wb_word);
            end
        end
        if (mem_op_done) done_cnt++;
    end

    // Memory model: one transaction at a time, aborted by reset.
    initial begin
        mem_data_ready = 1'b0;
        mem_data_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_op_init) begin
                logic         op_l;
                logic [31:0]  addr_l;
                logic [127:0] wd_l;
                logic         aborted;
                op_l    = mem_op;
                addr_l  = mem_address;
                wd_l    = mem_data_in;
                aborted = 1'b0;
                repeat (MEM_LAT) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                end
                @(posedge clk);
                #1;
                if (!aborted) begin
                    if (op_l) mem_data_out = model_read(addr_l);
                    else mem_store[addr_l] = wd_l;
                    mem_data_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_data_ready = 1'b0;
                    mem_data_out   = '0;
                end
            end
        end
    end

    task automatic cpu_access(input logic [31:0] a, input logic rd, input logic bt,
                              input logic [31:0] d, output int cycles);
        logic done;
        @(posedge clk);
        #1;
        address = a;
        op      = rd;
        byte_op = bt;
        data_in = d;
        access  = 1'b1;
        cycles  = 0;
        done    = 1'b0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (data_ready) done = 1'b1;
        end
        access = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout_%h: got no data_ready in %0d cycles, required completion", a, cycles);
        end
    endtask

    task automatic push_cpu(input logic rd, input logic [31:0] d, input string n);
        cpu_exp_t e;
        e.is_read = rd;
        e.data    = d;
        e.name    = n;
        cpu_q.push_back(e);
    endtask

    task automatic push_mem(input logic o, input logic [31:0] a, input logic cw,
                            input logic [31:0] w, input string n);
        mem_exp_t m;
        m.op      = o;
        m.addr    = a;
        m.chk_wb  = cw;
        m.wb_word = w;
        m.name    = n;
        mem_q.push_back(m);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_data_ready"}, data_ready, 1'b0);
        check({pfx, "_data_out"}, data_out, 32'h0);
        check({pfx, "_mem_op_init"}, mem_op_init, 1'b0);
        check({pfx, "_mem_enable"}, mem_enable, 1'b0);
        check({pfx, "_mem_op"}, mem_op, 1'b0);
        check({pfx, "_mem_op_done"}, mem_op_done, 1'b0);
        check({pfx, "_mem_address"}, mem_address, 32'h0);
        check({pfx, "_mem_data_in"}, mem_data_in, 128'h0);
    endtask

    initial begin
        int n;
        int i0;
        int d0;
        int k;
        int drop_cyc;

        reset         = 1'b1;
        access        = 1'b0;
        address       = '0;
        data_in       = '0;
        op            = 1'b1;
        byte_op       = 1'b0;
        memory_in_use = 1'b0;
        mem_store[32'h1000] = 128'h44444444_33333333_22222222_11111111;
        mem_store[32'h1040] = 128'h88888888_77777777_66666666_55555555;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Cold read: a single refill of line 0x1000.
        push_mem(1'b1, 32'h1000, 1'b0, 32'h0, "cold_rf");
        push_cpu(1'b1, 32'h11111111, "cold_read");
        i0 = init_cnt;
        d0 = done_cnt;
        cpu_access(32'h1000, 1'b1, 1'b0, 32'h0, n);
        check("cold_init_pulses", init_cnt - i0, 1);
        check("cold_done_pulses", done_cnt - d0, 1);

        // Hit on the same line: one-cycle latency, no memory traffic.
        push_cpu(1'b1, 32'h33333333, "hit_read_1008");
        i0 = init_cnt;
        cpu_access(32'h1008, 1'b1, 1'b0, 32'h0, n);
        check("hit_latency", n, 1);
        check("hit_no_mem_traffic", init_cnt - i0, 0);

        push_cpu(1'b1, 32'h00000011, "byte_read_1001");
        cpu_access(32'h1001, 1'b1, 1'b1, 32'h0, n);

        push_cpu(1'b0, 32'h0, "byte_write_1004");
        cpu_access(32'h1004, 1'b0, 1'b1, 32'hFFFF_FFAB, n);
        push_cpu(1'b1, 32'h222222AB, "word_read_1004");
        cpu_access(32'h1004, 1'b1, 1'b0, 32'h0, n);

        // Same index, new tag, dirty victim: write-back then refill.
        push_mem(1'b0, 32'h1000, 1'b1, 32'h222222AB, "evict_wb");
        push_mem(1'b1, 32'h1040, 1'b0, 32'h0, "evict_rf");
        push_cpu(1'b1, 32'h55555555, "read_1040");
        d0 = done_cnt;
        cpu_access(32'h1040, 1'b1, 1'b0, 32'h0, n);
        check("evict_done_pulses", done_cnt - d0, 2);

        // Clean victim: refill only; the written-back byte comes back from memory.
        push_mem(1'b1, 32'h1000, 1'b0, 32'h0, "reload_rf");
        push_cpu(1'b1, 32'h222222AB, "reload_read_1004");
        cpu_access(32'h1004, 1'b1, 1'b0, 32'h0, n);

        // Memory busy for several cycles while the refill waits.
        memory_in_use = 1'b1;
        drop_cyc = 0;
        push_mem(1'b1, 32'h1050, 1'b0, 32'h0, "busy_rf");
        push_cpu(1'b1, 32'h00001050, "busy_read_1050");
        fork
            cpu_access(32'h1050, 1'b1, 1'b0, 32'h0, n);
            begin
                repeat (6) @(posedge clk);
                #1;
                memory_in_use = 1'b0;
                drop_cyc = cyc;
            end
        join
        check("busy_init_cycle", last_init_cyc, drop_cyc + 1);
        push_cpu(1'b1, 32'h00001058, "hit_read_1058");
        cpu_access(32'h1058, 1'b1, 1'b0, 32'h0, n);

        // Dirty the 0x1000 line, then reset in the middle of another refill.
        push_cpu(1'b0, 32'h0, "word_write_1000");
        cpu_access(32'h1000, 1'b0, 1'b0, 32'hCAFEF00D, n);
        push_mem(1'b1, 32'h1020, 1'b0, 32'h0, "abort_rf");
        @(posedge clk);
        #1;
        address = 32'h1020;
        op      = 1'b1;
        byte_op = 1'b0;
        access  = 1'b1;
        k = 0;
        while (!mem_op_init && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!mem_op_init) begin
            tests++;
            fails++;
            $display("FAIL abort_wait: got no mem_op_init in %0d cycles, required one", k);
        end
        reset  = 1'b1;
        access = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_mid");
        reset = 1'b0;

        // Dirty data was discarded: plain refill, original memory contents.
        push_mem(1'b1, 32'h1000, 1'b0, 32'h0, "post_reset_rf");
        push_cpu(1'b1, 32'h11111111, "post_reset_read");
        i0 = init_cnt;
        cpu_access(32'h1000, 1'b1, 1'b0, 32'h0, n);
        check("post_reset_miss", init_cnt - i0, 1);

        repeat (4) @(posedge clk);
        check("cpu_queue_empty", cpu_q.size(), 0);
        check("mem_queue_empty", mem_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_unit.md
# icache_unit

Direct-mapped, write-back, write-allocate cache serving one 32-bit CPU port and refilling 128-bit lines from main memory. It sits between the fetch stage (as instruction cache) or the memory stage (as data cache) and the shared `Memory` block. The memory port is arbitrated externally through `memory_in_use`.

## Interface
Parameters:
- `ADDRESS_SIZE`, default 32: byte address width.
- `WORD_SIZE`, default 32: CPU data width.
- `CACHE_LINE_SIZE`, default 128: line width in bits (16 bytes).
- `NUM_LINES`, default 4: number of lines; must be a power of two.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous active-high reset.
- `access`, in, 1: request valid; sampled only in LOOKUP.
- `address`, in, 32: byte address.
- `data_in`, in, 32: write data; the byte is taken from `[7:0]`.
- `op`, in, 1: 1 = read, 0 = write.
- `byte_op`, in, 1: 1 = byte access, 0 = word access.
- `mem_data_ready`, in, 1: memory has a valid `mem_data_out` (read) or has accepted a write.
- `mem_data_out`, in, 128: refill line.
- `memory_in_use`, in, 1: memory is busy with another requester.
- `data_out`, out, 32: read result.
- `data_ready`, out, 1: one-cycle completion pulse.
- `mem_op_init`, out, 1: one-cycle transaction start pulse.
- `mem_enable`, out, 1: held high for the whole memory transaction.
- `mem_op`, out, 1: 1 = line read, 0 = line write.
- `mem_op_done`, out, 1: one-cycle pulse when a memory transaction is consumed.
- `mem_address`, out, 32: line-aligned address (`[3:0]` = 0).
- `mem_data_in`, out, 128: write-back line.

## Operation
- Address split with defaults:
  - offset = `address[3:0]`; word select = `[3:2]`.
  - index = `[5:4]`.
  - tag = `[31:6]`.
  - Widths are derived from the parameters.
- Per line: valid bit, dirty bit, tag, 128-bit data.
- Word accesses ignore `address[1:0]`.
- Byte reads return the byte zero-extended in `data_out[7:0]`.
- Writes update only the addressed word or byte and set dirty.
- States are LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT and RF_DONE.
- LOOKUP with `access`=1:
  - Hit (valid and tag match): perform the read or write and go to the completion cycle.
  - Miss on a dirty line: go to WB_REQ.
  - Miss otherwise: go to RF_REQ.
- WB_REQ / RF_REQ:
  - Wait while `memory_in_use`=1.
  - Then drive `mem_enable`=1 and `mem_address`, with `mem_op`=0 and `mem_data_in` = the victim line (WB) or `mem_op`=1 (RF).
  - Pulse `mem_op_init` for one cycle and enter the matching WAIT state.
- WB_WAIT: on `mem_data_ready`, pulse `mem_op_done`, clear dirty, go to RF_REQ.
- RF_WAIT: on `mem_data_ready`, capture `mem_data_out` into the line, set valid, set tag, clear dirty; go to RF_DONE.
- RF_DONE: pulse `mem_op_done`, drop `mem_enable`, return to LOOKUP. The retried access then hits.
- `data_out` holds its value until the next completed read.

## Timing
- Reset values: all valid and dirty bits 0, state LOOKUP, every output 0.
- Reset mid-transaction: `mem_enable` drops the next cycle and dirty data is discarded.
- Hit: `access` sampled at edge N gives `data_ready`=1 and valid `data_out` during cycle N+1. The next access is sampled at edge N+1.
- A held `access` produces back-to-back hit completions every cycle.
- Miss latency is 2 cycles + memory latency + 1 retry-hit cycle, plus the write-back transaction if the victim is dirty.
- `mem_op_init` never asserts while `memory_in_use`=1.
- CPU inputs are ignored outside LOOKUP; the requester holds them stable until `data_ready`.
- `mem_data_ready` in a non-WAIT state is ignored.

## Configuration
- `CACHE_STATS_EN` defined: adds two outputs, `hit_count` (32-bit) and `miss_count` (32-bit).
  - Both are zeroed by reset.
  - `hit_count` increments once per LOOKUP hit, including the retry hit after a refill.
  - `miss_count` increments once per miss, at LOOKUP.
  - Both counters wrap at 2^32.
- `CACHE_STATS_EN` undefined: the two ports and the counters do not exist.

## Structure
- Package `cache_pkg` holds:
  - the state enum;
  - `OP_READ`=1 and `OP_WRITE`=0;
  - localparam functions for the offset, index and tag widths.
- One sub-module, `cache_line_store`: the tag, valid, dirty and data arrays, with a word/byte write-merge port and a full-line refill port.

## Test plan
- Cold read at 0x1000: one refill with `mem_address`=0x1000 and a single `mem_op_init`. Memory returns 0x44444444_33333333_22222222_11111111, giving `data_out`=0x11111111 and one `mem_op_done` pulse.
- Read 0x1008 after the cold read: hit, no memory traffic, `data_out`=0x33333333 one cycle after `access`.
- Byte read at 0x1001: `data_out`=0x00000011.
- Byte write 0xAB to 0x1004, then word read 0x1004: `data_out`=0x222222AB.
- Read 0x1040 (same index, new tag) after the byte write: write-back with `mem_op`=0, `mem_address`=0x1000 and `mem_data_in[63:32]`=0x222222AB, then refill of 0x1040.
- `memory_in_use`=1 for 5 cycles during a miss: `mem_op_init` stays 0 until the cycle after it drops.
- `reset` during RF_WAIT: the next cycle shows all outputs 0, and a following read of 0x1000 misses.
